// File: rtl/pulse_train_ctrl_pkg.sv
// Shared definitions for the pulse-train controller: default widths and FSM state encoding.
package pulse_train_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_REP_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StCount = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_train_ctrl_rep_down_counter.sv
// Loadable down counter tracking the remaining pulses of a train; saturates at zero.
module pulse_train_ctrl_rep_down_counter
    import pulse_train_ctrl_pkg::*;
#(
    parameter int unsigned REP_W = DEFAULT_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [REP_W-1:0] din,
    input  logic             dec,
    output logic             last,
    output logic             zero
);

    logic [REP_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (ld) begin
            count_d = din;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == REP_W'(1));
    assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_train_ctrl.sv
// Drives an external loadable down counter to produce N pulses spaced P+2 cycles apart,
// then strobes done. All outputs are registered.
module pulse_train_ctrl
    import pulse_train_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned REP_W = DEFAULT_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] period,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    input  logic             co,
    output logic             ld,
    output logic [WIDTH-1:0] pi,
    output logic             dcen,
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] period_q;
    logic             req_ok, accept, expire;
    logic             rep_last, rep_zero;
    logic             ld_d, dcen_d, pulse_d, busy_d, done_d;

    assign req_ok = (period != '0) && (reps != '0);
    assign accept = (state_q == StIdle) && start && req_ok;
    // abort wins over a coincident carry-out, so that expiry never produces a pulse
    assign expire = (state_q == StCount) && co && !abort;

    pulse_train_ctrl_rep_down_counter #(
        .REP_W (REP_W)
    ) u_rep (
        .clk  (clk),
        .rst  (rst),
        .ld   (accept),
        .din  (reps),
        .dec  (expire),
        .last (rep_last),
        .zero (rep_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            period_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                period_q <= period;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  state_d = abort ? StIdle : StCount;
            StCount: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (co) begin
                    state_d = (rep_last || rep_zero) ? StDone : StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the upcoming state so they line up with it after the register.
    always_comb begin
        ld_d    = (state_d == StLoad);
        dcen_d  = (state_d == StCount);
        pulse_d = expire;
        busy_d  = (state_d != StIdle);
        done_d  = (state_q == StDone) || ((state_q == StIdle) && start && !req_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld    <= 1'b0;
            dcen  <= 1'b0;
            pulse <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ld    <= ld_d;
            dcen  <= dcen_d;
            pulse <= pulse_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    assign pi = period_q;

endmodule
